// File: rtl/mac_cluster_seq.sv
// mac_cluster_seq
//   Job sequencer for one quad MAC cluster. It takes a dot-product job,
//   loads the cluster config, pulses the cluster clear, and gates the cluster
//   enable per operand beat. It then drains the cluster/combiner pipeline
//   with zero-forced operands and presents the four accumulators on a
//   valid/ready result port. Operand data goes straight to the cluster; only
//   the handshake, enable and zero-force select come from here.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   job_valid/job_ready      job handshake (ready only while idle)
//   job_mode                 00 single, 01 dual, 10 quad, 11 illegal (dropped)
//   job_conf                 config bits; [1:0] replaced by job_mode
//   job_len                  number of operand beats
//   job_init                 four initial accumulator words, word i at [i*ACC +: ACC]
//   op_valid/op_ready        operand beat handshake toward the cluster inputs
//   op_zero                  forces cluster operand muxes to zero
//   mac_rst, mac_en          cluster clear (loads init from mac_cfg) and enable
//   mac_cfg                  {init3,init2,init1,init0,conf}
//   mac_out0..3              cluster accumulator outputs
//   res_valid/res_ready      result handshake
//   res0..3                  captured results
//   busy                     sequencer not idle
//   err_illegal              one-cycle pulse when a mode 11 job is dropped
module mac_cluster_seq #(
   parameter int MAC_ACC_WIDTH  = 32,
   parameter int MAC_CONF_WIDTH = 4,
   parameter int LEN_WIDTH      = 16,
   parameter int PIPE_LAT       = 2
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    job_valid,
   output logic                                    job_ready,
   input  logic [1:0]                              job_mode,
   input  logic [MAC_CONF_WIDTH-1:0]               job_conf,
   input  logic [LEN_WIDTH-1:0]                    job_len,
   input  logic [4*MAC_ACC_WIDTH-1:0]              job_init,
   input  logic                                    op_valid,
   output logic                                    op_ready,
   output logic                                    op_zero,
   output logic                                    mac_rst,
   output logic                                    mac_en,
   output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg,
   input  logic [MAC_ACC_WIDTH-1:0]                mac_out0,
   input  logic [MAC_ACC_WIDTH-1:0]                mac_out1,
   input  logic [MAC_ACC_WIDTH-1:0]                mac_out2,
   input  logic [MAC_ACC_WIDTH-1:0]                mac_out3,
   output logic                                    res_valid,
   input  logic                                    res_ready,
   output logic [MAC_ACC_WIDTH-1:0]                res0,
   output logic [MAC_ACC_WIDTH-1:0]                res1,
   output logic [MAC_ACC_WIDTH-1:0]                res2,
   output logic [MAC_ACC_WIDTH-1:0]                res3,
   output logic                                    busy,
   output logic                                    err_illegal
);

   localparam int DRN_W = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_RESULT
   } state_t;

   state_t                    state;
   logic [LEN_WIDTH-1:0]      len_q;
   logic [LEN_WIDTH-1:0]      beat_cnt;
   logic [DRN_W-1:0]          drain_cnt;
   logic [MAC_CONF_WIDTH-1:0] conf_next;

   // Mode always overrides the low config bits of the offered job.
   always_comb begin
      conf_next      = job_conf;
      conf_next[1:0] = job_mode;
   end

   // Outputs decode straight from the state register. job_ready is also
   // masked by rst so the fabric never sees ready while reset is held.
   assign job_ready = (state == S_IDLE) & ~rst;
   assign busy      = (state != S_IDLE);
   assign mac_rst   = rst | (state == S_CLEAR);
   assign op_ready  = (state == S_RUN);
   assign op_zero   = (state != S_RUN);
   assign mac_en    = (state == S_RUN) ? op_valid : (state == S_DRAIN);
   assign res_valid = (state == S_RESULT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         mac_cfg     <= '0;
         len_q       <= '0;
         beat_cnt    <= '0;
         drain_cnt   <= '0;
         res0        <= '0;
         res1        <= '0;
         res2        <= '0;
         res3        <= '0;
         err_illegal <= 1'b0;
      end else begin
         err_illegal <= 1'b0;
         case (state)
            S_IDLE: begin
               if (job_valid) begin
                  if (job_mode == 2'b11) begin
                     // Illegal job is consumed but leaves the cluster untouched.
                     err_illegal <= 1'b1;
                  end else begin
                     mac_cfg <= {job_init, conf_next};
                     len_q   <= job_len;
                     state   <= S_CLEAR;
                  end
               end
            end
            S_CLEAR: begin
               state <= (len_q != '0) ? S_RUN : S_DRAIN;
            end
            S_RUN: begin
               // beat_cnt never exceeds len-1, so a full-range len cannot wrap.
               if (op_valid) begin
                  if (beat_cnt == len_q - LEN_WIDTH'(1)) begin
                     beat_cnt <= '0;
                     state    <= S_DRAIN;
                  end else begin
                     beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                  end
               end
            end
            S_DRAIN: begin
               // Cluster outputs are final at the edge ending the last drain cycle.
               if (drain_cnt == DRN_LAST) begin
                  drain_cnt <= '0;
                  res0      <= mac_out0;
                  res1      <= mac_out1;
                  res2      <= mac_out2;
                  res3      <= mac_out3;
                  state     <= S_RESULT;
               end else begin
                  drain_cnt <= drain_cnt + DRN_W'(1);
               end
            end
            S_RESULT: begin
               if (res_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_cluster_seq.sv
module tb_mac_cluster_seq;

   localparam int ACC  = 32;
   localparam int CONF = 4;
   localparam int LW   = 16;
   localparam int PL   = 2;
   localparam int NV   = 6;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    job_valid, job_ready;
   logic [1:0]              job_mode;
   logic [CONF-1:0]         job_conf;
   logic [LW-1:0]           job_len;
   logic [4*ACC-1:0]        job_init;
   logic                    op_valid, op_ready, op_zero;
   logic                    mac_rst, mac_en;
   logic [4*ACC+CONF-1:0]   mac_cfg;
   logic [ACC-1:0]          mac_out0, mac_out1, mac_out2, mac_out3;
   logic                    res_valid, res_ready;
   logic [ACC-1:0]          res0, res1, res2, res3;
   logic                    busy, err_illegal;
   logic [4*ACC-1:0]        res_bus;

   always #5 clk = ~clk;

   mac_cluster_seq #(
      .MAC_ACC_WIDTH(ACC), .MAC_CONF_WIDTH(CONF), .LEN_WIDTH(LW), .PIPE_LAT(PL)
   ) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode),
      .job_conf(job_conf), .job_len(job_len), .job_init(job_init),
      .op_valid(op_valid), .op_ready(op_ready), .op_zero(op_zero),
      .mac_rst(mac_rst), .mac_en(mac_en), .mac_cfg(mac_cfg),
      .mac_out0(mac_out0), .mac_out1(mac_out1), .mac_out2(mac_out2), .mac_out3(mac_out3),
      .res_valid(res_valid), .res_ready(res_ready),
      .res0(res0), .res1(res1), .res2(res2), .res3(res3),
      .busy(busy), .err_illegal(err_illegal)
   );

   assign res_bus = {res3, res2, res1, res0};

   // Behavioural cluster: one product stage, then accumulate. All lanes see
   // the same operands; mac_rst loads the init words from mac_cfg.
   logic [ACC-1:0] a_op, b_op;
   logic [ACC-1:0] acc_m  [4];
   logic [ACC-1:0] prod_m [4];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mac_rst) begin
            acc_m[i]  <= mac_cfg[CONF + i*ACC +: ACC];
            prod_m[i] <= '0;
         end else if (mac_en) begin
            prod_m[i] <= op_zero ? '0 : a_op * b_op;
            acc_m[i]  <= acc_m[i] + prod_m[i];
         end
      end
   end

   assign mac_out0 = acc_m[0];
   assign mac_out1 = acc_m[1];
   assign mac_out2 = acc_m[2];
   assign mac_out3 = acc_m[3];

   typedef struct {
      logic [1:0]       mode;
      logic [CONF-1:0]  conf;
      logic [LW-1:0]    len;
      logic [4*ACC-1:0] init;
      logic [ACC-1:0]   a_base;
      logic [ACC-1:0]   b;
      logic [15:0]      mask;     // op_valid per RUN cycle; 1 beyond bit 15
      logic [4*ACC-1:0] exp_res;
   } vec_t;

   vec_t             vt [NV];
   logic [4*ACC-1:0] sb_q [$];
   int               n_vec = 0;
   int               n_err = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic bound_fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic set_vec(input int i, input logic [1:0] mode, input logic [CONF-1:0] conf,
                          input logic [LW-1:0] len, input logic [4*ACC-1:0] init,
                          input logic [ACC-1:0] a_base, input logic [ACC-1:0] b,
                          input logic [15:0] mask, input logic [4*ACC-1:0] exp_res);
      vt[i].mode = mode;  vt[i].conf = conf;  vt[i].len = len;  vt[i].init = init;
      vt[i].a_base = a_base;  vt[i].b = b;  vt[i].mask = mask;  vt[i].exp_res = exp_res;
   endtask

   task automatic wait_ready();
      int b = 0;
      while (job_ready !== 1'b1 && b < 100) begin
         @(negedge clk);
         b++;
      end
      if (job_ready !== 1'b1) bound_fail("wait_job_ready");
   endtask

   task automatic offer(input int v);
      job_mode  = vt[v].mode;
      job_conf  = vt[v].conf;
      job_len   = vt[v].len;
      job_init  = vt[v].init;
      job_valid = 1'b1;
   endtask

   // Entered at the negedge of the CLEAR cycle; returns at the negedge where
   // res_valid is first seen, after checking latency, config and results.
   task automatic run_body(input int v);
      int lat, runc, beat, exp_run, ones, exp_lat;
      logic en_bad;
      logic [63:0] en_tr, rst_tr, zero_tr;
      logic [4*ACC-1:0] want;
      exp_run = 0;
      ones    = 0;
      while (ones < int'(vt[v].len)) begin
         if (exp_run >= 16 || vt[v].mask[exp_run]) ones++;
         exp_run++;
      end
      exp_lat = exp_run + 2 + PL;
      lat = 1;  runc = 0;  beat = 0;  en_bad = 1'b0;
      en_tr = '0;  rst_tr = '0;  zero_tr = '0;
      while (1) begin
         if (lat > 200) begin
            bound_fail("wait_res_valid");
            break;
         end
         if (op_ready) begin
            op_valid = (runc >= 16) ? 1'b1 : vt[v].mask[runc];
            a_op     = vt[v].a_base + ACC'(beat);
            b_op     = vt[v].b;
            #1;
            if (mac_en !== op_valid) en_bad = 1'b1;
            if (op_valid) beat++;
            runc++;
         end else begin
            op_valid = 1'b0;
            a_op     = 32'd99;
            b_op     = 32'd77;
            #1;
         end
         if (lat < 64) begin
            en_tr[lat]   = mac_en;
            rst_tr[lat]  = mac_rst;
            zero_tr[lat] = op_zero;
         end
         if (res_valid) break;
         @(negedge clk);
         lat++;
      end
      op_valid = 1'b0;
      check($sformatf("latency_v%0d", v), lat, exp_lat);
      check($sformatf("run_cycles_v%0d", v), runc, exp_run);
      check($sformatf("mac_en_gating_v%0d", v), en_bad, 1'b0);
      check($sformatf("mac_cfg_v%0d", v), mac_cfg, {vt[v].init, vt[v].conf[CONF-1:2], vt[v].mode});
      if (v == 0) begin
         check("trace_mac_en_v0", en_tr[15:0], 16'h00FC);
         check("trace_mac_rst_v0", rst_tr[15:0], 16'h0002);
         check("trace_op_zero_v0", zero_tr[15:0], 16'h01C2);
      end
      if (sb_q.size() == 0) begin
         bound_fail("scoreboard_empty");
      end else begin
         want = sb_q.pop_front();
         check($sformatf("results_v%0d", v), res_bus, want);
      end
   endtask

   task automatic do_handshake();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("res_valid_drop", res_valid, 1'b0);
      check("job_ready_after_result", job_ready, 1'b1);
   endtask

   task automatic run_job(input int v);
      wait_ready();
      offer(v);
      sb_q.push_back(vt[v].exp_res);
      @(negedge clk);
      job_valid = 1'b0;
      check($sformatf("clear_state_v%0d", v), {busy, mac_rst, job_ready}, 3'b110);
      run_body(v);
      do_handshake();
   endtask

   initial begin
      logic [4*ACC+CONF-1:0] cfg_save;
      int   beats;
      logic seen_res;

      rst = 1'b1;  job_valid = 1'b0;  job_mode = '0;  job_conf = '0;  job_len = '0;
      job_init = '0;  op_valid = 1'b0;  res_ready = 1'b0;  a_op = '0;  b_op = '0;

      //          mode   conf   len    init {w3,w2,w1,w0}                                     a     b    mask      expected {w3,w2,w1,w0}
      set_vec(0, 2'b00, 4'hF, 16'd4, {32'd0, 32'd0, 32'd0, 32'd10},                          32'd1, 32'd2, 16'hFFFF, {32'd20, 32'd20, 32'd20, 32'd30});
      set_vec(1, 2'b01, 4'h4, 16'd3, {32'd0, 32'd0, 32'd200, 32'd100},                      32'd5, 32'd3, 16'h0019, {32'd54, 32'd54, 32'd254, 32'd154});
      set_vec(2, 2'b10, 4'h8, 16'd0, {32'd8, 32'd7, 32'd6, 32'd5},                           32'd3, 32'd3, 16'hFFFF, {32'd8, 32'd7, 32'd6, 32'd5});
      set_vec(3, 2'b10, 4'h0, 16'd1, {32'd1000, 32'd0, 32'd0, 32'd0},                        32'd7, 32'd9, 16'hFFFF, {32'd1063, 32'd63, 32'd63, 32'd63});
      set_vec(4, 2'b00, 4'hA, 16'd5, {32'd4, 32'd3, 32'd2, 32'd1},                           32'd0, 32'd4, 16'hFFEF, {32'd44, 32'd43, 32'd42, 32'd41});
      set_vec(5, 2'b01, 4'h3, 16'd2, {32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFF0},           32'd2, 32'd5, 16'hFFFF, {32'h18, 32'd25, 32'd25, 32'd9});

      repeat (2) @(negedge clk);
      // {job_ready,busy,op_ready,mac_en,res_valid,err_illegal,mac_rst,op_zero}
      check("reset_ctrl", {job_ready, busy, op_ready, mac_en, res_valid, err_illegal, mac_rst, op_zero}, 8'b0000_0011);
      check("reset_cfg", mac_cfg, '0);
      check("reset_res", res_bus, '0);
      rst = 1'b0;
      #1;
      check("ready_after_reset", job_ready, 1'b1);

      for (int v = 0; v < NV; v++) run_job(v);

      // Illegal mode: dropped with a one-cycle error pulse.
      wait_ready();
      cfg_save  = mac_cfg;
      job_mode  = 2'b11;
      job_conf  = 4'h5;
      job_len   = 16'd5;
      job_init  = {4{32'hDEAD_BEEF}};
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      check("illegal_pulse", {err_illegal, busy, mac_rst, job_ready}, 4'b1001);
      check("illegal_cfg_kept", mac_cfg, cfg_save);
      @(negedge clk);
      check("illegal_pulse_end", {err_illegal, busy}, 2'b00);

      // Result backpressure with the next job already offered.
      wait_ready();
      offer(3);
      sb_q.push_back(vt[3].exp_res);
      @(negedge clk);
      job_valid = 1'b0;
      run_body(3);
      offer(2);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("hold_res_%0d", k), res_bus, vt[3].exp_res);
         check($sformatf("hold_flags_%0d", k), {res_valid, job_ready}, 2'b10);
      end
      sb_q.push_back(vt[2].exp_res);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("b2b_idle", {res_valid, job_ready}, 2'b01);
      @(negedge clk);
      job_valid = 1'b0;
      check("b2b_accepted", {busy, mac_rst}, 2'b11);
      run_body(2);
      do_handshake();

      // Reset in the middle of a len-8 job after three beats.
      wait_ready();
      job_mode  = 2'b10;
      job_conf  = 4'h0;
      job_len   = 16'd8;
      job_init  = {32'd4, 32'd3, 32'd2, 32'd1};
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      beats = 0;
      for (int k = 0; k < 20 && beats < 3; k++) begin
         @(negedge clk);
         if (op_ready) begin
            op_valid = 1'b1;
            a_op     = 32'd3;
            b_op     = 32'd3;
            beats++;
         end
      end
      @(negedge clk);
      check("midrun_in_run", op_ready, 1'b1);
      rst = 1'b1;
      #1;
      check("midrun_reset_ctrl", {job_ready, busy, op_ready, mac_en, res_valid, err_illegal, mac_rst, op_zero}, 8'b0000_0011);
      check("midrun_reset_cfg", mac_cfg, '0);
      check("midrun_reset_res", res_bus, '0);
      op_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("midrun_mac_rst_%0d", k), mac_rst, 1'b1);
      end
      rst = 1'b0;
      #1;
      check("midrun_release", {job_ready, busy}, 2'b10);
      seen_res = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (res_valid) seen_res = 1'b1;
      end
      check("midrun_no_result", seen_res, 1'b0);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mac_cluster_seq.md
Name: mac_cluster_seq

Overview:
Job sequencer for one quad MAC cluster. It accepts a dot-product job (mode, beat count, initial accumulator values), loads the cluster config, and pulses the cluster clear. It then gates the cluster enable per operand beat, drains the cluster and combiner pipeline with zero operands, and returns the four accumulator results over a valid/ready interface. It sits between the job-issuing fabric and the cluster. The operand data path (A0..B3) bypasses this block; the block only drives the handshake, the enable and the zero-force select.

Parameters:
MAC_ACC_WIDTH, 32, accumulator and result word width
MAC_CONF_WIDTH, 4, config bit width; bits [1:0] carry mode
LEN_WIDTH, 16, width of job beat count
PIPE_LAT, 2, drain cycles from last operand beat until cluster outputs are final; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
job_valid  in  1  job offered
job_ready  out  1  high only in IDLE
job_mode  in  2  00 single, 01 dual, 10 quad, 11 illegal
job_conf  in  MAC_CONF_WIDTH  remaining config bits; bits [1:0] ignored and replaced by job_mode
job_len  in  LEN_WIDTH  number of operand beats
job_init  in  4*MAC_ACC_WIDTH  initial accumulator values; word i at [(i+1)*ACC-1 : i*ACC]
op_valid  in  1  operand beat present on the cluster A/B inputs
op_ready  out  1  operand beat consumed
op_zero  out  1  forces the cluster operand muxes to zero
mac_rst  out  1  cluster reset/clear; loads init values from mac_cfg
mac_en  out  1  cluster enable
mac_cfg  out  4*MAC_ACC_WIDTH+MAC_CONF_WIDTH  {init3,init2,init1,init0,conf}; conf at [CONF-1:0]; word i at [CONF+(i+1)*ACC-1 : CONF+i*ACC]
mac_out0..mac_out3  in  MAC_ACC_WIDTH each  cluster outputs
res_valid  out  1  results available
res_ready  in  1  results consumed
res0..res3  out  MAC_ACC_WIDTH each  captured results
busy  out  1  state != IDLE
err_illegal  out  1  one-cycle pulse when a mode 11 job is dropped

Behaviour:
- Reset (async, rst=1): state IDLE; mac_cfg, res0..3, beat and drain counters = 0; res_valid, mac_en, op_ready, err_illegal, busy, job_ready = 0; op_zero = 1.
- mac_rst = rst OR (state==CLEAR). mac_rst is asserted throughout reset.
- States: IDLE, CLEAR, RUN, DRAIN, RESULT.
- IDLE:
  - job_ready=1.
  - On job_valid, mode != 11: register mac_cfg = {job_init, job_conf[CONF-1:2], job_mode}; latch len; go to CLEAR.
  - On job_valid, mode == 11: accept the job, pulse err_illegal for the next cycle, leave mac_cfg unchanged, stay in IDLE.
- CLEAR: exactly 1 cycle. mac_rst=1, mac_en=0. Next state is RUN if len != 0, otherwise DRAIN.
- RUN:
  - op_ready=1, op_zero=0, mac_en=op_valid (combinational).
  - Each cycle with op_valid: beat_cnt++.
  - On the beat where beat_cnt==len-1: go to DRAIN and clear beat_cnt.
  - op_valid low inserts a stall; mac_en=0 that cycle.
- DRAIN: exactly PIPE_LAT cycles. mac_en=1, op_zero=1, op_ready=0. On the edge ending the last DRAIN cycle, res0..3 <= mac_out0..3 and the state goes to RESULT.
- RESULT:
  - res_valid=1; res0..3 held stable.
  - On res_ready: res_valid drops next cycle and the state goes to IDLE. Results stay in the res registers until the next capture.
- op_zero=1 and op_ready=0 in every state except RUN. mac_en=0 in IDLE and RESULT.
- mac_cfg holds its value from job acceptance until the next legal acceptance.
- Latency, no stalls, len=N: accept at edge of cycle T; CLEAR at T+1; RUN at T+2..T+N+1; DRAIN at T+N+2..T+N+1+PIPE_LAT; res_valid high from T+N+2+PIPE_LAT. Each op_valid stall adds 1 cycle.
- Back-to-back: a new job is accepted no earlier than the cycle after the res handshake.
- Reset mid-job aborts immediately. No result is produced, and the cluster is cleared via mac_rst.
- len = 2^LEN_WIDTH-1 must complete without counter wrap.

Test Plan:
1. Assert rst for 3 cycles mid-RUN (len 8, beat 3) -> all outputs at reset values immediately, mac_rst=1 during reset, job_ready=1 the first cycle after release, no res_valid.
2. Single mode, len 4, init0=10, A0=1,2,3,4, B0=2, PIPE_LAT=2, behavioural cluster model -> mac_rst at cycle 1, mac_en cycles 2-7 (op_zero cycles 6-7), res_valid at cycle 8, res0=30.
3. len 3, op_valid pattern 1,0,0,1,1 -> mac_en mirrors op_valid, exactly 3 beats counted, DRAIN begins the cycle after the 5th RUN cycle.
4. len 0, quad mode, init0..3=5,6,7,8 -> CLEAR, 2 DRAIN cycles, res0..3 equal the model outputs for zero operands (5,6,7,8 per model), mac_cfg[1:0]=10.
5. job_mode=11 -> err_illegal high exactly 1 cycle, mac_cfg unchanged, no mac_rst, busy stays 0.
6. Hold res_ready low 5 cycles with job_valid high -> res0..3 stable, job_ready=0. After res_ready, res_valid drops and the new job is accepted the following cycle.
